boot_program_memory: RTL and testbench

- Next-generation program memory with sequential HALT clear on reset and a chunked loader port for writing programs at run time.
- Sits between the boot/debug link, which streams program bytes in, and the fetch stage, which reads instructions through a registered port.
- Word width, depth and loader chunk width are parametrised.

---
 rtl/boot_program_memory_pkg.sv | 16 +
 rtl/boot_program_memory_chunk_assembler.sv | 55 +++++
 rtl/boot_program_memory.sv | 155 +++++++++++++++
 tb/tb_boot_program_memory.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/boot_program_memory_pkg.sv
// Shared architecture constants and FSM encoding for the boot program memory.
package boot_program_memory_pkg;

  localparam int ARCH_ADDRESS_SIZE     = 8;
  localparam int ARCH_INSTRUCTION_SIZE = 32;
  localparam int ARCH_PROG_MEMORY_SIZE = 16;
  localparam int PROG_LOAD_CHUNK_SIZE  = 8;
  localparam logic [ARCH_INSTRUCTION_SIZE-1:0] ARCH_HALT_INST = 32'hFC00_0000;

  typedef enum logic [1:0] {
    BPM_CLEAR = 2'd0,
    BPM_IDLE  = 2'd1,
    BPM_LOAD  = 2'd2
  } bpm_state_e;

endpackage

// File: rtl/boot_program_memory_chunk_assembler.sv
// Packs CHUNK_SIZE loader chunks, least significant first, into one DATA_SIZE word.
module boot_program_memory_chunk_assembler
  import boot_program_memory_pkg::*;
#(
  parameter int DATA_SIZE  = ARCH_INSTRUCTION_SIZE,
  parameter int CHUNK_SIZE = PROG_LOAD_CHUNK_SIZE
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  chunk_valid,
  input  logic [CHUNK_SIZE-1:0] chunk_data,
  output logic [DATA_SIZE-1:0]  word,
  output logic                  word_complete
);

  localparam int CHUNKS = DATA_SIZE / CHUNK_SIZE;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(CHUNKS - 1);

  logic [CW-1:0]        count_r;
  logic [DATA_SIZE-1:0] word_r;
  logic [DATA_SIZE-1:0] assembled_s;
  logic                 last_chunk_s;

  // Merge the incoming chunk into its slot of the partial word.
  always_comb begin
    assembled_s = word_r;
    assembled_s[count_r*CHUNK_SIZE +: CHUNK_SIZE] = chunk_data;
    last_chunk_s = (count_r == LAST_COUNT);
  end

  assign word          = assembled_s;
  assign word_complete = chunk_valid && last_chunk_s;

  // Chunk counter and partial word; clear drops any partial word.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
      word_r  <= {DATA_SIZE{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
      word_r  <= {DATA_SIZE{1'b0}};
    end else if (chunk_valid) begin
      if (last_chunk_s) begin
        count_r <= {CW{1'b0}};
        word_r  <= {DATA_SIZE{1'b0}};
      end else begin
        count_r <= count_r + CW'(1);
        word_r  <= assembled_s;
      end
    end
  end

endmodule

// File: rtl/boot_program_memory.sv
// Program memory: HALT clear after reset, chunked run-time loader, registered fetch port.
module boot_program_memory
  import boot_program_memory_pkg::*;
#(
  parameter int ADDRESS_SIZE = ARCH_ADDRESS_SIZE,
  parameter int DATA_SIZE    = ARCH_INSTRUCTION_SIZE,
  parameter int SIZE         = ARCH_PROG_MEMORY_SIZE,
  parameter int CHUNK_SIZE   = PROG_LOAD_CHUNK_SIZE,
  parameter logic [DATA_SIZE-1:0] HALT_WORD = ARCH_HALT_INST
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load_start,
  input  logic [ADDRESS_SIZE-1:0] load_base,
  input  logic                    load_valid,
  input  logic [CHUNK_SIZE-1:0]   load_data,
  input  logic                    load_last,
  output logic                    load_ready,
  input  logic [ADDRESS_SIZE-1:0] fetch_address,
  output logic [DATA_SIZE-1:0]    fetch_data,
  output logic                    fetch_valid,
  output logic                    busy,
  output logic                    load_done,
  output logic                    load_error
);

  localparam int AW = ADDRESS_SIZE;
  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [AW:0]   SIZE_W   = (AW+1)'(SIZE);
  localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

  bpm_state_e           state_r, next_state_s;
  logic [IW-1:0]        clear_ptr_r;
  logic [AW:0]          ptr_r;
  logic                 busy_r, load_ready_r, load_done_r, load_error_r;
  logic                 fetch_valid_r;
  logic [DATA_SIZE-1:0] fetch_data_r;
  logic [DATA_SIZE-1:0] mem_r [SIZE];

  logic                 accept_s, start_s, asm_clear_s, word_write_s;
  logic                 ptr_in_range_s, fetch_in_range_s, base_bad_s;
  logic [DATA_SIZE-1:0] word_s;
  logic                 word_complete_s;

  boot_program_memory_chunk_assembler #(
    .DATA_SIZE  (DATA_SIZE),
    .CHUNK_SIZE (CHUNK_SIZE)
  ) u_chunk_assembler (
    .clock         (clock),
    .reset         (reset),
    .clear         (asm_clear_s),
    .chunk_valid   (accept_s),
    .chunk_data    (load_data),
    .word          (word_s),
    .word_complete (word_complete_s)
  );

  // Session control strobes and range checks.
  always_comb begin
    accept_s         = (state_r == BPM_LOAD) && load_valid;
    start_s          = (state_r == BPM_IDLE) && load_start;
    asm_clear_s      = start_s || (accept_s && load_last);
    ptr_in_range_s   = (ptr_r < SIZE_W);
    word_write_s     = word_complete_s && ptr_in_range_s;
    fetch_in_range_s = ({1'b0, fetch_address} < SIZE_W);
    base_bad_s       = ({1'b0, load_base} >= SIZE_W);
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      BPM_CLEAR: begin
        if (clear_ptr_r == LAST_IDX) next_state_s = BPM_IDLE;
        else                         next_state_s = BPM_CLEAR;
      end
      BPM_IDLE: begin
        if (load_start) next_state_s = BPM_LOAD;
        else            next_state_s = BPM_IDLE;
      end
      BPM_LOAD: begin
        if (accept_s && load_last) next_state_s = BPM_IDLE;
        else                       next_state_s = BPM_LOAD;
      end
      default: next_state_s = BPM_CLEAR;
    endcase
  end

  // State, pointers and status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= BPM_CLEAR;
      clear_ptr_r  <= {IW{1'b0}};
      ptr_r        <= {(AW+1){1'b0}};
      busy_r       <= 1'b1;
      load_ready_r <= 1'b0;
      load_done_r  <= 1'b0;
      load_error_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      busy_r       <= (next_state_s != BPM_IDLE);
      load_ready_r <= (next_state_s == BPM_LOAD);
      load_done_r  <= accept_s && load_last;

      if (state_r == BPM_CLEAR && clear_ptr_r != LAST_IDX) clear_ptr_r <= clear_ptr_r + IW'(1);
      else                                                 clear_ptr_r <= {IW{1'b0}};

      // Pointer saturates rather than wrapping so overflow stays out of range.
      if (start_s) begin
        ptr_r <= {1'b0, load_base};
      end else if (word_complete_s && ptr_r != {(AW+1){1'b1}}) begin
        ptr_r <= ptr_r + (AW+1)'(1);
      end

      if (start_s) begin
        load_error_r <= base_bad_s;
      end else if (word_complete_s && !ptr_in_range_s) begin
        load_error_r <= 1'b1;
      end else if (accept_s && load_last && !word_complete_s) begin
        load_error_r <= 1'b1;
      end
    end
  end

  // Memory array: HALT fill during CLEAR, assembled words during LOAD.
  always_ff @(posedge clock) begin
    if (!reset && state_r == BPM_CLEAR) begin
      mem_r[clear_ptr_r] <= HALT_WORD;
    end else if (!reset && word_write_s) begin
      mem_r[ptr_r[IW-1:0]] <= word_s;
    end
  end

  // Registered fetch port; served only in IDLE, old contents on a same-edge write.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_valid_r <= 1'b0;
      fetch_data_r  <= HALT_WORD;
    end else if (state_r == BPM_IDLE && fetch_in_range_s) begin
      fetch_valid_r <= 1'b1;
      fetch_data_r  <= mem_r[fetch_address[IW-1:0]];
    end else begin
      fetch_valid_r <= 1'b0;
      fetch_data_r  <= HALT_WORD;
    end
  end

  assign load_ready  = load_ready_r;
  assign busy        = busy_r;
  assign load_done   = load_done_r;
  assign load_error  = load_error_r;
  assign fetch_valid = fetch_valid_r;
  assign fetch_data  = fetch_data_r;

endmodule

// File: tb/tb_boot_program_memory.sv
// Self-checking bench: per-cycle behavioural model plus directed literal checks.
module tb_boot_program_memory;
  import boot_program_memory_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SZ = 16;
  localparam int CK = 8;
  localparam logic [DW-1:0] HALT = ARCH_HALT_INST;

  logic          clock;
  logic          reset;
  logic          load_start;
  logic [AW-1:0] load_base;
  logic          load_valid;
  logic [CK-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic [AW-1:0] fetch_address;
  logic [DW-1:0] fetch_data;
  logic          fetch_valid;
  logic          busy;
  logic          load_done;
  logic          load_error;

  boot_program_memory #(
    .ADDRESS_SIZE (AW),
    .DATA_SIZE    (DW),
    .SIZE         (SZ),
    .CHUNK_SIZE   (CK),
    .HALT_WORD    (HALT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .load_start    (load_start),
    .load_base     (load_base),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_last     (load_last),
    .load_ready    (load_ready),
    .fetch_address (fetch_address),
    .fetch_data    (fetch_data),
    .fetch_valid   (fetch_valid),
    .busy          (busy),
    .load_done     (load_done),
    .load_error    (load_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Behavioural model state
  bit            live = 1'b0;
  int            m_phase;   // 0 clearing, 1 idle, 2 loading
  int            m_cnt, m_ptr, m_chunks;
  logic [DW-1:0] m_word;
  logic [DW-1:0] m_mem [SZ];
  logic          m_err, e_fv, e_done, e_busy, e_ready;
  logic [DW-1:0] e_fd;

  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        m_phase = 0; m_cnt = 0; m_chunks = 0; m_word = '0; m_err = 1'b0;
        e_fv = 1'b0; e_fd = HALT; e_done = 1'b0; e_busy = 1'b1; e_ready = 1'b0;
        live = 1'b1;
      end else if (live) begin
        e_fv   = (m_phase == 1) && (fetch_address < SZ);
        e_fd   = e_fv ? m_mem[fetch_address[3:0]] : HALT;
        e_done = 1'b0;
        case (m_phase)
          0: begin
            m_mem[m_cnt] = HALT;
            m_cnt++;
            if (m_cnt == SZ) m_phase = 1;
          end
          1: if (load_start) begin
            m_ptr = int'(load_base); m_chunks = 0; m_word = '0;
            m_err = (load_base >= SZ); m_phase = 2;
          end
          2: if (load_valid) begin
            m_word = m_word | (32'(load_data) << (CK * m_chunks));
            m_chunks++;
            if (m_chunks == DW / CK) begin
              if (m_ptr < SZ) m_mem[m_ptr] = m_word;
              else m_err = 1'b1;
              m_ptr++; m_chunks = 0; m_word = '0;
            end else if (load_last) begin
              m_err = 1'b1;
            end
            if (load_last) begin
              m_phase = 1; e_done = 1'b1; m_chunks = 0; m_word = '0;
            end
          end
          default: ;
        endcase
        e_busy  = (m_phase != 1);
        e_ready = (m_phase == 2);
      end
      #1;
      if (live) begin
        check("model busy", busy, e_busy);
        check("model load_ready", load_ready, e_ready);
        check("model load_done", load_done, e_done);
        check("model load_error", load_error, m_err);
        check("model fetch_valid", fetch_valid, e_fv);
        check("model fetch_data", fetch_data, e_fd);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic reset_and_count(input string tag);
    int cnt;
    reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    tick();
    reset = 1'b0;
    check({tag, " reset fetch_valid"}, fetch_valid, 32'd0);
    check({tag, " reset fetch_data"}, fetch_data, HALT);
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    check({tag, " busy cycles"}, 32'(cnt), 32'd16);
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < SZ; a++) begin
      fetch_address = 8'(a);
      tick();
      check({tag, " sweep valid"}, fetch_valid, 32'd1);
      check({tag, " sweep data"}, fetch_data, HALT);
    end
  endtask

  task automatic start_load(input logic [AW-1:0] base);
    load_start = 1'b1; load_base = base;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send(input logic [CK-1:0] data, input logic last);
    load_valid = 1'b1; load_data = data; load_last = last;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load_start = 1'b0; load_base = '0; load_valid = 1'b0;
    load_data = '0; load_last = 1'b0; fetch_address = '0;

    reset_and_count("boot");
    sweep("boot");
    fetch_address = 8'd20;
    tick();
    check("fetch 20 valid", fetch_valid, 32'd0);
    check("fetch 20 data", fetch_data, HALT);

    // Single word at base 3
    fetch_address = 8'd0;
    start_load(8'd3);
    send(8'h78, 1'b0); send(8'h56, 1'b0); send(8'h34, 1'b0); send(8'h12, 1'b1);
    check("base3 done", load_done, 32'd1);
    check("base3 error", load_error, 32'd0);
    fetch_address = 8'd3;
    tick();
    check("base3 fetch data", fetch_data, 32'h1234_5678);
    check("base3 fetch valid", fetch_valid, 32'd1);
    check("base3 done once", load_done, 32'd0);
    check("model mem3", m_mem[3], 32'h1234_5678);

    // Two words from base 15 with fetch of 3 held throughout
    start_load(8'd15);
    check("start-cycle fetch valid", fetch_valid, 32'd1);
    check("start-cycle fetch data", fetch_data, 32'h1234_5678);
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    check("base15 first word error", load_error, 32'd0);
    check("load fetch valid", fetch_valid, 32'd0);
    check("load fetch data", fetch_data, HALT);
    send(8'h55, 1'b0); send(8'h66, 1'b0); send(8'h77, 1'b0); send(8'h88, 1'b1);
    check("base15 overflow error", load_error, 32'd1);
    check("base15 done", load_done, 32'd1);
    tick();
    check("first idle fetch valid", fetch_valid, 32'd1);
    check("first idle fetch data", fetch_data, 32'h1234_5678);
    tick(); tick();
    check("sticky error", load_error, 32'd1);
    fetch_address = 8'd15;
    tick();
    check("fetch 15 data", fetch_data, 32'h4433_2211);

    // Early last on 2nd chunk at base 5
    start_load(8'd5);
    check("error cleared by start", load_error, 32'd0);
    send(8'hAA, 1'b0); send(8'hBB, 1'b1);
    check("partial error", load_error, 32'd1);
    check("partial done", load_done, 32'd1);
    fetch_address = 8'd5;
    tick();
    check("fetch 5 data", fetch_data, HALT);
    check("fetch 5 valid", fetch_valid, 32'd1);

    // Out-of-range base flags at once
    start_load(8'd20);
    check("bad base error", load_error, 32'd1);
    send(8'h01, 1'b1);
    check("bad base done", load_done, 32'd1);

    // Reset in the middle of a session
    start_load(8'd7);
    send(8'h01, 1'b0); send(8'h02, 1'b0);
    reset_and_count("midload");
    sweep("midload");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
